// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16 -- 16x oversampling UART receiver (8N1, optional even parity)
//
// Receives LSB-first bytes from an asynchronous idle-high serial line. The
// line is sampled 16 times per bit. The start bit is confirmed at its middle.
// Each data bit, and the stop bit, is then sampled one bit period later.
// Completed bytes go into a one-entry holding register with a valid/ready
// handshake.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// after data bit 7. This also adds the parity_err output port.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   line bit rate in bits/s
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     received byte, valid while rx_valid=1
//   rx_valid    holding register contains a byte
//   rx_ready    consumer accepts the byte when rx_valid=1 and rx_ready=1
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   overrun     one-cycle pulse when a completed byte is dropped
//   parity_err  one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
   parameter int CLK_FREQ  = 1000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic             r_rx_meta;
   logic             r_rx_s;
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_tick;

   logic [2:0]       r_state;
   logic [3:0]       r_os_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_armed;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_frame_err;
   logic             r_overrun;
   logic             r_busy;

   logic [2:0]       w_state_nx;
   logic [3:0]       w_os_nx;
   logic [2:0]       w_bit_nx;
   logic [7:0]       w_shift_nx;
   logic             w_armed_nx;
   logic             w_stop_ok;
   logic             w_stop_bad;
   logic             w_byte_ok;
   logic             w_accept;
   logic             w_deliver;

`ifdef UART_RX_PARITY_EN
   logic             r_par_bad;
   logic             r_parity_err;
   logic             w_par_bad_nx;
   logic             w_par_pulse;
`endif

   // Two-flop synchronizer; both stages reset to the idle (high) level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Free-running 16x baud tick divider, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   assign w_tick = (r_div_cnt == DIV_LAST);

   // Receive FSM next-state logic; only tick cycles advance it
   always_comb begin
      w_state_nx = r_state;
      w_os_nx    = r_os_cnt;
      w_bit_nx   = r_bit_cnt;
      w_shift_nx = r_shift;
      w_armed_nx = r_armed;
      w_stop_ok  = 1'b0;
      w_stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nx = r_par_bad;
      w_par_pulse  = 1'b0;
`endif
      if (w_tick) begin
         case (r_state)
            S_IDLE: begin
               // A start edge is accepted only after the line was seen idle,
               // so a stuck-low line after a framing error cannot retrigger.
               if (r_armed && !r_rx_s) begin
                  w_state_nx = S_START;
                  w_os_nx    = 4'd0;
                  w_armed_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
                  w_par_bad_nx = 1'b0;
`endif
               end else if (r_rx_s) begin
                  w_armed_nx = 1'b1;
               end else begin
                  w_armed_nx = r_armed;
               end
            end
            S_START: begin
               // Confirm the start bit at its middle; a high line is a glitch
               if (r_os_cnt == 4'd7) begin
                  w_os_nx = 4'd0;
                  if (!r_rx_s) begin
                     w_state_nx = S_DATA;
                     w_bit_nx   = 3'd0;
                  end else begin
                     w_state_nx = S_IDLE;
                  end
               end else begin
                  w_os_nx = r_os_cnt + 4'd1;
               end
            end
            S_DATA: begin
               // os_cnt wraps 15->0, so each bit sample is one bit period apart
               w_os_nx = r_os_cnt + 4'd1;
               if (r_os_cnt == 4'd15) begin
                  w_shift_nx = {r_rx_s, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     w_bit_nx = 3'd0;
`ifdef UART_RX_PARITY_EN
                     w_state_nx = S_PARITY;
`else
                     w_state_nx = S_STOP;
`endif
                  end else begin
                     w_bit_nx = r_bit_cnt + 3'd1;
                  end
               end else begin
                  w_bit_nx = r_bit_cnt;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               w_os_nx = r_os_cnt + 4'd1;
               if (r_os_cnt == 4'd15) begin
                  // Even parity: the parity bit equals the XOR of the data bits
                  w_par_bad_nx = (r_rx_s != (^r_shift));
                  w_par_pulse  = (r_rx_s != (^r_shift));
                  w_state_nx   = S_STOP;
               end else begin
                  w_par_bad_nx = r_par_bad;
               end
            end
`endif
            S_STOP: begin
               w_os_nx = r_os_cnt + 4'd1;
               if (r_os_cnt == 4'd15) begin
                  w_state_nx = S_IDLE;
                  if (r_rx_s) begin
                     w_stop_ok = 1'b1;
                  end else begin
                     w_stop_bad = 1'b1;
                  end
               end else begin
                  w_state_nx = S_STOP;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_os_nx    = 4'd0;
               w_bit_nx   = 3'd0;
            end
         endcase
      end else begin
         w_state_nx = r_state;
      end
   end

`ifdef UART_RX_PARITY_EN
   assign w_byte_ok = !r_par_bad;
`else
   assign w_byte_ok = 1'b1;
`endif

   assign w_accept  = r_rx_valid & rx_ready;
   assign w_deliver = w_stop_ok & w_byte_ok;

   // FSM state, counters and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_os_cnt  <= 4'd0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
         r_armed   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_os_cnt  <= w_os_nx;
         r_bit_cnt <= w_bit_nx;
         r_shift   <= w_shift_nx;
         r_armed   <= w_armed_nx;
         r_busy    <= (w_state_nx != S_IDLE);
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch flag for the frame in progress and its error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_par_bad    <= w_par_bad_nx;
         r_parity_err <= w_par_pulse;
      end
   end

   assign parity_err = r_parity_err;
`endif

   // Holding register: load on a good stop bit when empty or being drained;
   // otherwise the new byte is dropped and the stored byte is preserved.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_stop_bad;
         if (w_deliver && (!r_rx_valid || w_accept)) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            r_overrun  <= 1'b0;
         end else if (w_deliver) begin
            r_rx_valid <= 1'b1;
            r_overrun  <= 1'b1;
         end else if (w_accept) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
         end else begin
            r_rx_valid <= r_rx_valid;
            r_overrun  <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16 -- scoreboard bench for uart_rx_os16
//
// CLK_FREQ=16000 and BAUD_RATE=1000 give DIV=1, so one bit lasts 16 clocks.
// Stimulus pushes the expected bytes and error events into queues. A monitor
// on the falling clock edge then pops and compares each accepted byte and
// each error pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx_os16;

   localparam int CLK_FREQ  = 16000;
   localparam int BAUD_RATE = 1000;
   localparam int BIT_CLKS  = 16;

   localparam logic [1:0] EV_FE = 2'd0;
   localparam logic [1:0] EV_OV = 2'd1;
   localparam logic [1:0] EV_PE = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_data_q[$];
   logic [1:0] exp_evt_q[$];

   uart_rx_os16 #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic pop_data(input logic [7:0] act);
      logic [7:0] e;
      if (exp_data_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_byte: got %02h, required no byte", act);
      end else begin
         e = exp_data_q.pop_front();
         check("rx_data", {24'd0, act}, {24'd0, e});
      end
   endtask

   task automatic pop_evt(input logic [1:0] kind);
      logic [1:0] e;
      if (exp_evt_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d, required no event", kind);
      end else begin
         e = exp_evt_q.pop_front();
         check("error_event_kind", {30'd0, kind}, {30'd0, e});
      end
   endtask

   // Monitor: compare every accepted byte and every error pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) pop_data(rx_data);
         if (frame_err) pop_evt(EV_FE);
         if (overrun) pop_evt(EV_OV);
`ifdef UART_RX_PARITY_EN
         if (parity_err) pop_evt(EV_PE);
`endif
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      rx = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick_n(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = ^d;
      tick_n(BIT_CLKS);
`endif
      rx = stop_b;
      tick_n(BIT_CLKS);
      rx = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] d, input logic par_b);
      rx = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick_n(BIT_CLKS);
      end
      rx = par_b;
      tick_n(BIT_CLKS);
      rx = 1'b1;
      tick_n(BIT_CLKS);
   endtask
`endif

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic seen_busy;
      logic cleared;
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      tick_n(3);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      tick_n(20);

      // Plain frame with the consumer always ready
      exp_data_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick_n(16);
      check("a5_valid_dropped", {31'd0, rx_valid}, 32'd0);
      check("a5_busy_idle", {31'd0, busy}, 32'd0);

      // 4-clock low glitch: the start is rejected at mid-bit. The 2-flop
      // synchronizer adds 2 clocks on top of the 10-clock bound.
      seen_busy = 1'b0;
      cleared   = 1'b0;
      rx = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick_n(1);
         if (k == 4) rx = 1'b1;
         if (busy) seen_busy = 1'b1;
         if (seen_busy && !busy) cleared = 1'b1;
      end
      check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
      check("glitch_busy_cleared", {31'd0, cleared}, 32'd1);
      tick_n(30);

      // Framing error, one idle bit, then a good frame
      exp_evt_q.push_back(EV_FE);
      send_frame(8'h3C, 1'b0);
      check("fe_no_valid", {31'd0, rx_valid}, 32'd0);
      tick_n(BIT_CLKS);
      exp_data_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      tick_n(16);

      // Overrun: hold the first byte and drop the second
      rx_ready = 1'b0;
      exp_data_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      tick_n(4);
      exp_evt_q.push_back(EV_OV);
      send_frame(8'h22, 1'b1);
      tick_n(8);
      check("ovr_event_seen", exp_evt_q.size(), 32'd0);
      check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
      check("ovr_data_held", {24'd0, rx_data}, 32'h11);
      rx_ready = 1'b1;
      tick_n(1);
      check("ovr_valid_drops", {31'd0, rx_valid}, 32'd0);
      check("ovr_byte_popped", exp_data_q.size(), 32'd0);
      tick_n(16);

      // Reset in the middle of data bit 4
      rx = 1'b0;
      tick_n(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick_n(BIT_CLKS);
      end
      rx = 1'b1;
      tick_n(8);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      check("rst_busy_clear", {31'd0, busy}, 32'd0);
      check("rst_no_valid", {31'd0, rx_valid}, 32'd0);
      tick_n(40);
      check("rst_still_idle", {31'd0, busy}, 32'd0);
      exp_data_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      tick_n(16);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones, so even parity requires a parity bit of 1
      exp_evt_q.push_back(EV_PE);
      send_frame_par(8'h07, 1'b0);
      check("pe_no_valid", {31'd0, rx_valid}, 32'd0);
      exp_data_q.push_back(8'h07);
      send_frame_par(8'h07, 1'b1);
      tick_n(16);
`endif

      tick_n(20);
      check("data_queue_empty", exp_data_q.size(), 32'd0);
      check("event_queue_empty", exp_evt_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data  output  8  received byte; valid while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  byte available in holding register.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid=1 and rx_ready=1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch; present only when UART_RX_PARITY_EN is defined.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-014 SHALL generate a 1-clk tick every DIV clocks, DIV = CLK_FREQ/(BAUD_RATE*16) (integer division, forced to 1 if 0); the divider runs freely and is cleared only by rst.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP, using a 4-bit oversample counter os_cnt and a 3-bit bit counter.
REQ-016 SHALL arm in IDLE only after rx_s=1 is sampled on a tick (reset leaves it armed); armed IDLE + tick + rx_s=0 -> START with os_cnt=0.
REQ-017 SHALL, in START, sample rx_s on the tick where os_cnt=7: 0 -> DATA with os_cnt=0 and bit counter=0; 1 -> IDLE (glitch rejected, no output).
REQ-018 SHALL, in DATA, sample rx_s on each tick where os_cnt=15, shifting LSB first; after bit 7 -> STOP (or PARITY with the macro).
REQ-019 SHALL, in STOP, sample rx_s at os_cnt=15: 1 -> deliver byte per REQ-021; 0 -> frame_err pulse, discard byte, disarm; both -> IDLE.
REQ-020 SHALL keep os_cnt wrapping 15->0 within a state; the bit counter wraps 7->0 only on leaving DATA.
REQ-021 SHALL deliver a byte by loading rx_data and setting rx_valid in the cycle after the stop sample, if rx_valid=0 or an accept (rx_valid&rx_ready) occurs in that same stop-sample cycle.
REQ-022 SHALL, if rx_valid=1 and no accept in the stop-sample cycle, keep the old rx_data, drop the new byte and pulse overrun.
REQ-023 SHALL clear rx_valid the cycle after an accept unless REQ-021 reloads it; rx_data SHALL not change while rx_valid=1 without an accept.
REQ-024 SHALL drive frame_err, overrun, parity_err high for exactly one clk per event.

Reset
REQ-025 SHALL on rst: FSM=IDLE armed, counters=0, tick divider=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
REQ-026 SHALL abort any frame in progress on rst, discarding partial data with no error pulse.

Configuration
REQ-027 SHALL, with UART_RX_PARITY_EN defined, expect an even-parity bit after bit 7 (sampled at os_cnt=15 in PARITY); mismatch -> parity_err pulse, byte discarded, STOP still processed.
REQ-028 SHALL, without UART_RX_PARITY_EN, implement 8N1 only: DATA -> STOP directly, no PARITY state, no parity_err port.

Verification (bench: CLK_FREQ=16000, BAUD_RATE=1000 -> DIV=1, 16 clk/bit)
REQ-029 SHALL cover: frame 0xA5 8N1, rx_ready=1 -> rx_valid for 1 clk, rx_data=0xA5, no error pulses.
REQ-030 SHALL cover: 4-clk low glitch on idle rx -> no rx_valid, busy back to 0 within 10 clk of glitch start.
REQ-031 SHALL cover: frame 0x3C with stop bit 0 -> frame_err pulse, rx_valid stays 0; next valid frame 0x81 after 1 idle bit received correctly.
REQ-032 SHALL cover: rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 held, overrun pulse at second stop; then rx_ready=1 -> rx_valid drops next clk.
REQ-033 SHALL cover: rst pulsed during data bit 4 -> busy=0 next clk, no rx_valid; following frame 0x5A -> rx_data=0x5A.
REQ-034 SHALL cover (macro defined): 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; 0x07 with parity bit 1 -> rx_data=0x07.
